// File: rtl/fifo_regfile.sv
// fifo_regfile: DEPTH x WIDTH storage array for param_peek_fifo.
// One synchronous write port and one combinational read port; the array
// itself is never reset, only the pointers that qualify its contents.
module fifo_regfile #(
  parameter int WIDTH      = 6,
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 2 ** DEPTH_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry when the top accepts a push.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_peek_fifo.sv
// param_peek_fifo: parametrised synchronous FIFO with random-access peek,
// occupancy count, almost-full threshold and sticky overflow/underflow flags.
// Push and pop are independent; a push into a full FIFO is accepted when a
// pop drains an entry in the same cycle.
module param_peek_fifo #(
  parameter int WIDTH      = 6,
  parameter int DEPTH_BITS = 4,
  parameter int AF_LEVEL   = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DEPTH_BITS-1:0] peek_idx,
  input  logic                  clear_err,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty_n,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_BITS:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH   = 2 ** DEPTH_BITS;
  localparam int COUNT_W = DEPTH_BITS + 1;

  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [COUNT_W-1:0]    count_q;
  logic [DEPTH_BITS-1:0] peek_addr;
  logic [WIDTH-1:0]      peek_word;
  logic                  peek_hit;
  logic                  push_ok;
  logic                  pop_ok;

  // Status is decoded from the registered count only.
  assign count       = count_q;
  assign empty_n     = (count_q != '0);
  assign full        = (count_q == COUNT_W'(DEPTH));
  assign almost_full = (count_q >= COUNT_W'(AF_LEVEL));

  // A pop needs something to take; a push needs room, or a same-cycle pop
  // (a full FIFO is never empty, so any pop there is accepted).
  assign pop_ok  = pop && empty_n;
  assign push_ok = push && (!full || pop);

  // Peek address wraps with the pointers; slots beyond the occupancy read 0.
  assign peek_addr = rd_ptr + peek_idx;
  assign peek_hit  = ({1'b0, peek_idx} < count_q);

  fifo_regfile #(
    .WIDTH      (WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_regfile (
    .clk   (clk),
    .we    (push_ok && reset_n && !flush),
    .waddr (wr_ptr),
    .wdata (push_data),
    .raddr (peek_addr),
    .rdata (peek_word)
  );

  // Pointer and occupancy update; flush discards contents but keeps flags.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered peek using pre-edge pointer, count and storage.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) rd_data <= '0;
    else                   rd_data <= peek_hit ? peek_word : '0;
  end

  // Sticky error flags; a fresh error outranks clear_err in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!flush) begin
      overflow  <= (overflow  && !clear_err) || (push && !push_ok);
      underflow <= (underflow && !clear_err) || (pop  && !pop_ok);
    end
  end

endmodule

// File: tb/tb_param_peek_fifo.sv
// Directed bench for param_peek_fifo (WIDTH 6, DEPTH 16, AF_LEVEL 14).
module tb_param_peek_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       push;
  logic [5:0] push_data;
  logic       pop;
  logic       flush;
  logic [3:0] peek_idx;
  logic       clear_err;
  logic [5:0] rd_data;
  logic       empty_n;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_pass   = 0;

  param_peek_fifo #(
    .WIDTH      (6),
    .DEPTH_BITS (4),
    .AF_LEVEL   (14)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (push),
    .push_data   (push_data),
    .pop         (pop),
    .flush       (flush),
    .peek_idx    (peek_idx),
    .clear_err   (clear_err),
    .rd_data     (rd_data),
    .empty_n     (empty_n),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; flush = 1'b0; clear_err = 1'b0; reset_n = 1'b1;
  endtask

  initial begin
    idle();
    push_data = '0;
    peek_idx  = '0;

    // Reset state
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rst_count", count, 0);
    check("rst_empty_n", empty_n, 0);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
    check("rst_rd", rd_data, 0);

    // Fill with 1..16; almost_full from count 14
    for (int i = 1; i <= 16; i++) begin
      push = 1'b1; push_data = 6'(i);
      step();
      check("fill_count", count, i);
      check("fill_af", almost_full, (i >= 14));
    end
    check("fill_full", full, 1);
    check("fill_head", rd_data, 1);

    // 17th push refused
    push_data = 6'h3F;
    step();
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);

    // Push 0x2A with pop from full
    push_data = 6'h2A; pop = 1'b1;
    step();
    check("pp_count", count, 16);
    check("pp_rd", rd_data, 1);
    push = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      check("drain_rd", rd_data, k + 2);
    end
    check("drain_count", count, 1);
    pop = 1'b0;
    step();
    check("head_2a", rd_data, 6'h2A);
    pop = 1'b1;
    step();
    check("pop_2a", rd_data, 6'h2A);
    check("pop_2a_count", count, 0);
    pop = 1'b0; clear_err = 1'b1;
    step();
    check("ovf_clear", overflow, 0);
    clear_err = 1'b0;

    // Peek into 5,6,7
    push = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      push_data = 6'(i);
      step();
    end
    push = 1'b0;
    peek_idx = 4'd0; step(); check("peek0", rd_data, 5);
    peek_idx = 4'd1; step(); check("peek1", rd_data, 6);
    peek_idx = 4'd2; step(); check("peek2", rd_data, 7);
    peek_idx = 4'd3; step(); check("peek3", rd_data, 0);
    peek_idx = 4'd0;
    pop = 1'b1;
    step(); step(); step();
    pop = 1'b0;
    check("peek_empty", count, 0);

    // Pop on empty with push 0x11
    pop = 1'b1; push = 1'b1; push_data = 6'h11;
    step();
    check("udf_set", underflow, 1);
    check("udf_count", count, 1);
    idle();
    step();
    check("udf_rd", rd_data, 6'h11);
    clear_err = 1'b1;
    step();
    check("udf_clear", underflow, 0);
    clear_err = 1'b0; pop = 1'b1;
    step();
    pop = 1'b0;
    check("udf_drain", count, 0);

    // Wrap-around from a fresh reset
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    push = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push_data = 6'(i); step();
    end
    push = 1'b0; pop = 1'b1;
    for (int i = 0; i < 12; i++) step();
    pop = 1'b0; push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_data = 6'(8'h30 + i); step();
    end
    push = 1'b0;
    check("wrap_count8", count, 8);
    pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("wrap_rd", rd_data, 8'h30 + i);
    end
    pop = 1'b0;
    check("wrap_count0", count, 0);

    // Flush at count 5 with push asserted
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_data = 6'(8'h20 + i); step();
    end
    check("pre_flush", count, 5);
    flush = 1'b1; push_data = 6'h15;
    step();
    check("flush_count", count, 0);
    check("flush_rd", rd_data, 0);
    check("flush_empty_n", empty_n, 0);
    idle();
    step();
    check("flush_nopush", rd_data, 0);
    check("flush_count2", count, 0);

    // Reset in the middle of traffic
    pop = 1'b1;
    step();
    check("mid_udf", underflow, 1);
    pop = 1'b0; push = 1'b1; push_data = 6'h09;
    step(); step();
    check("mid_count", count, 2);
    reset_n = 1'b0;
    step();
    check("mid_rst_count", count, 0);
    check("mid_rst_rd", rd_data, 0);
    check("mid_rst_udf", underflow, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_empty_n", empty_n, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_af", almost_full, 0);
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_peek_fifo.md
# param_peek_fifo

Parametrised synchronous FIFO with random-access peek, occupancy count, almost-full threshold and sticky error flags. It is the next generation of the team's 6-bit/16-entry pin-multiplexed FIFO: data width, depth and threshold are now parameters, push and pop are independent and can occur in the same cycle, and flush and error reporting are added. It sits behind the chip-level pin wrapper, which maps io pins onto these ports.

## Interface
- WIDTH, 6, data word width in bits (≥1)
- DEPTH_BITS, 4, log2 of entry count; DEPTH = 2**DEPTH_BITS
- AF_LEVEL, 14, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)

- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- push  in  1  write push_data this cycle
- push_data  in  WIDTH  word to enqueue
- pop  in  1  dequeue head entry this cycle
- flush  in  1  discard all entries
- peek_idx  in  DEPTH_BITS  offset from head for rd_data (0 = head)
- clear_err  in  1  clear overflow/underflow
- rd_data  out  WIDTH  registered entry at head+peek_idx
- empty_n  out  1  count != 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_LEVEL
- count  out  DEPTH_BITS+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: push refused
- underflow  out  1  sticky: pop refused

## Operation
- State: wr_ptr, rd_ptr (DEPTH_BITS, wrap modulo DEPTH), count (DEPTH_BITS+1), rd_data, overflow, underflow.
- Priority each cycle: reset_n low > flush > push/pop.
- Reset: pointers 0, count 0, rd_data 0, overflow 0, underflow 0. Storage is not cleared.
- Flush: pointers 0, count 0, rd_data 0, push and pop ignored, error flags untouched.
- Push accepted when count < DEPTH, or when count == DEPTH and pop is accepted in the same cycle. Accepted push writes mem[wr_ptr] and increments wr_ptr.
- Pop accepted when count > 0. Accepted pop increments rd_ptr.
- count update: +1 for push only, −1 for pop only, unchanged for both or neither.
- Push refused (full, no pop) sets overflow. Pop refused (empty) sets underflow. A push accepted with a refused pop on empty still writes.
- clear_err clears both flags; a new error in the same cycle wins (flag stays 1).
- rd_data <= (peek_idx < count) ? mem[rd_ptr+peek_idx] : 0, using pre-edge rd_ptr, count and mem.
  - A popped word therefore appears on rd_data the cycle after pop.
  - Unoccupied slots always read as 0.
- empty_n, full, almost_full and count are combinational from registered count.

## Timing
- Push-to-visible latency: a word pushed at edge N is readable via rd_data after edge N+1 (empty → first read is 2 edges after push).
- Flags change on the edge that updates count; no combinational path from push/pop to flags.
- rd_data has a one-cycle latency from peek_idx.
- No handshake beyond push/pop qualification. The producer must watch full; errors are reported, never stalled.

## Structure
- No shared package. DEPTH and COUNT_W are module localparams.
- One sub-module, fifo_regfile: DEPTH×WIDTH register array with 1 write port (we, waddr, wdata) and 1 combinational read port (raddr). No reset on the array.
- Top holds pointers, count, flags and the rd_data register.

## Test plan
- Reset, then push 1..16 (WIDTH 6, DEPTH 16) → count 16, full 1, almost_full asserted from count 14. A 17th push → overflow 1, count stays 16.
- From full, push 0x2A with pop asserted → count stays 16; after 15 further pops, head is 0x2A.
- Fill with 5,6,7; peek_idx 0,1,2,3 → rd_data 5,6,7,0 on the following cycles.
- Empty FIFO, pop with push 0x11 → underflow 1, count 1, next-cycle read gives 0x11. clear_err → underflow 0.
- Wrap-around: 12 pushes, 12 pops, 8 pushes (0x30..0x37) → pops return 0x30..0x37 in order, count returns to 0.
- flush with push asserted at count 5 → count 0, rd_data 0, push ignored. reset_n low mid-traffic → all outputs zero on next edge.
